// File: rtl/simmem_rsp_delay_slots_if.sv
// Handshake bundle for the response-delay slot bank: reservation, response in, delayed response out.
interface simmem_rsp_delay_slots_if #(
  parameter int unsigned IdW      = 2,
  parameter int unsigned NumSlots = 8,
  parameter int unsigned DelayW   = 8,
  parameter int unsigned RspW     = 16
);
  localparam int unsigned OccW = $clog2(NumSlots + 1);

  logic              en_i;
  logic [DelayW-1:0] delay_i;
  logic              rsv_valid_i;
  logic              rsv_ready_o;
  logic [IdW-1:0]    rsv_id_i;
  logic              rsp_in_valid_i;
  logic              rsp_in_ready_o;
  logic [RspW-1:0]   rsp_in_i;
  logic              rsp_out_valid_o;
  logic              rsp_out_ready_i;
  logic [RspW-1:0]   rsp_out_o;
  logic [OccW-1:0]   occupancy_o;

  modport slave (
    input  en_i, delay_i, rsv_valid_i, rsv_id_i, rsp_in_valid_i, rsp_in_i, rsp_out_ready_i,
    output rsv_ready_o, rsp_in_ready_o, rsp_out_valid_o, rsp_out_o, occupancy_o
  );

  modport master (
    output en_i, delay_i, rsv_valid_i, rsv_id_i, rsp_in_valid_i, rsp_in_i, rsp_out_ready_i,
    input  rsv_ready_o, rsp_in_ready_o, rsp_out_valid_o, rsp_out_o, occupancy_o
  );
endinterface

// File: rtl/simmem_rsp_delay_slots.sv
// Response-delay slot bank: holds each response until its programmed latency has elapsed and
// every older same-ID response has been released.
module simmem_rsp_delay_slots #(
  parameter int unsigned NumIds   = 4,
  parameter int unsigned IdW      = 2,
  parameter int unsigned NumSlots = 8,
  parameter int unsigned DelayW   = 8,
  parameter int unsigned RspW     = 16
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  simmem_rsp_delay_slots_if.slave bus
);
  localparam int unsigned RankW = $clog2(NumSlots);
  localparam int unsigned IdxW  = $clog2(NumSlots);
  localparam int unsigned OccW  = $clog2(NumSlots + 1);

  if ((2 ** IdW) < NumIds || NumSlots < 2) begin : gen_param_check
    $error("simmem_rsp_delay_slots: illegal parameter combination");
  end

  typedef enum logic [1:0] {StFree, StWait, StHeld} slot_st_e;

  slot_st_e          state_q [NumSlots];
  slot_st_e          state_d [NumSlots];
  logic [IdW-1:0]    id_q    [NumSlots];
  logic [IdW-1:0]    id_d    [NumSlots];
  logic [DelayW-1:0] cnt_q   [NumSlots];
  logic [DelayW-1:0] cnt_d   [NumSlots];
  logic [RankW-1:0]  rank_q  [NumSlots];
  logic [RankW-1:0]  rank_d  [NumSlots];
  logic [RspW-1:0]   data_q  [NumSlots];
  logic [RspW-1:0]   data_d  [NumSlots];
  logic [OccW-1:0]   occ_q, occ_d;
  logic              lock_q, lock_d;
  logic [IdxW-1:0]   lock_idx_q, lock_idx_d;

  logic              any_free, in_found, any_elig, out_valid;
  logic              rsv_fire, in_fire, rel_fire;
  logic [IdxW-1:0]   free_idx, in_idx, elig_idx, win_idx;
  logic [RankW-1:0]  in_rank, rsv_rank;
  logic [IdW-1:0]    in_id, rel_id;
  logic [OccW-1:0]   same_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumSlots); i++) begin
        state_q[i] <= StFree;
        id_q[i]    <= '0;
        cnt_q[i]   <= '0;
        rank_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      occ_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      rank_q     <= rank_d;
      data_q     <= data_d;
      occ_q      <= occ_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Slot selection and outputs, all from cycle-start state.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    any_elig = 1'b0;
    elig_idx = '0;
    in_found = 1'b0;
    in_idx   = '0;
    in_rank  = '0;
    in_id    = bus.rsp_in_i[IdW-1:0];
    for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
      if (state_q[i] == StFree) begin
        any_free = 1'b1;
        free_idx = IdxW'(i);
      end
      if (state_q[i] == StHeld && cnt_q[i] == '0 && rank_q[i] == '0) begin
        any_elig = 1'b1;
        elig_idx = IdxW'(i);
      end
    end
    for (int i = 0; i < int'(NumSlots); i++) begin
      if (state_q[i] == StWait && id_q[i] == in_id && (!in_found || rank_q[i] < in_rank)) begin
        in_found = 1'b1;
        in_idx   = IdxW'(i);
        in_rank  = rank_q[i];
      end
    end
    // A presented winner stays selected until its handshake.
    win_idx   = lock_q ? lock_idx_q : elig_idx;
    out_valid = rst_ni & (lock_q | any_elig);
    rel_id    = id_q[win_idx];

    bus.rsv_ready_o     = rst_ni & bus.en_i & any_free;
    bus.rsp_in_ready_o  = rst_ni & bus.en_i & in_found;
    bus.rsp_out_valid_o = out_valid;
    bus.rsp_out_o       = data_q[win_idx];
    bus.occupancy_o     = occ_q;

    rsv_fire = bus.rsv_valid_i & bus.rsv_ready_o;
    in_fire  = bus.rsp_in_valid_i & bus.rsp_in_ready_o;
    rel_fire = out_valid & bus.rsp_out_ready_i;
  end

  always_comb begin
    same_cnt = '0;
    for (int i = 0; i < int'(NumSlots); i++) begin
      if (state_q[i] != StFree && id_q[i] == bus.rsv_id_i) same_cnt = same_cnt + OccW'(1);
    end
    if (rel_fire && rel_id == bus.rsv_id_i) same_cnt = same_cnt - OccW'(1);
    rsv_rank = RankW'(same_cnt);

    for (int i = 0; i < int'(NumSlots); i++) begin
      state_d[i] = state_q[i];
      id_d[i]    = id_q[i];
      data_d[i]  = data_q[i];
      rank_d[i]  = rank_q[i];
      cnt_d[i]   = (state_q[i] != StFree && cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : cnt_q[i];
      if (rel_fire && state_q[i] != StFree && id_q[i] == rel_id && rank_q[i] != '0) begin
        rank_d[i] = rank_q[i] - 1'b1;
      end
      if (rel_fire && win_idx == IdxW'(i)) state_d[i] = StFree;
      if (in_fire && in_idx == IdxW'(i)) begin
        state_d[i] = StHeld;
        data_d[i]  = bus.rsp_in_i;
      end
      if (rsv_fire && free_idx == IdxW'(i)) begin
        state_d[i] = StWait;
        id_d[i]    = bus.rsv_id_i;
        cnt_d[i]   = bus.delay_i;
        rank_d[i]  = rsv_rank;
      end
    end

    occ_d      = occ_q + OccW'(rsv_fire) - OccW'(rel_fire);
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (rel_fire) begin
      lock_d = 1'b0;
    end else if (out_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end
  end
endmodule

// File: tb/tb_simmem_rsp_delay_slots.sv
// Bench for the response-delay slot bank: directed vector table, corner-case sequences and a
// randomized run checked every cycle against a due-time/sequence-number model.
module tb_simmem_rsp_delay_slots;
  localparam int NSlots = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simmem_rsp_delay_slots_if #(.IdW(2), .NumSlots(8), .DelayW(8), .RspW(16)) bus ();

  simmem_rsp_delay_slots #(
    .NumIds(4), .IdW(2), .NumSlots(8), .DelayW(8), .RspW(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: each occupied slot knows its due cycle and a global reservation sequence number.
  typedef struct {
    bit          busy;
    bit          held;
    int          id;
    int          due;
    int          seq;
    logic [15:0] data;
  } mslot_t;

  mslot_t      ms[NSlots];
  int          seq_ctr = 0;
  bit          m_lock  = 0;
  int          m_win   = 0;
  int          m_free, m_tgt, m_elig;
  bit          e_rr, e_ir, e_ov;
  logic [15:0] e_od;
  int          e_occ;

  function automatic bit oldest(input int i);
    for (int j = 0; j < NSlots; j++)
      if (j != i && ms[j].busy && ms[j].id == ms[i].id && ms[j].seq < ms[i].seq) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_eval();
    m_free = -1; m_tgt = -1; m_elig = -1; e_occ = 0;
    for (int i = 0; i < NSlots; i++) begin
      if (!ms[i].busy && m_free < 0) m_free = i;
      if (ms[i].busy) e_occ++;
      if (ms[i].busy && !ms[i].held && ms[i].id == int'(bus.rsp_in_i[1:0]) &&
          (m_tgt < 0 || ms[i].seq < ms[m_tgt].seq)) m_tgt = i;
      if (m_elig < 0 && ms[i].busy && ms[i].held && cyc >= ms[i].due && oldest(i)) m_elig = i;
    end
    if (m_lock) m_elig = m_win;
    e_rr = rst_n && bus.en_i && m_free >= 0;
    e_ir = rst_n && bus.en_i && m_tgt >= 0;
    e_ov = rst_n && m_elig >= 0;
    e_od = e_ov ? ms[m_elig].data : 16'h0;
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      for (int i = 0; i < NSlots; i++) ms[i] = '{0, 0, 0, 0, 0, 16'h0};
      m_lock = 0;
      return;
    end
    if (e_ov && bus.rsp_out_ready_i) begin
      ms[m_elig].busy = 0;
      ms[m_elig].held = 0;
      m_lock = 0;
    end else if (e_ov) begin
      m_lock = 1;
      m_win  = m_elig;
    end
    if (bus.rsp_in_valid_i && e_ir) begin
      ms[m_tgt].held = 1;
      ms[m_tgt].data = bus.rsp_in_i;
    end
    if (bus.rsv_valid_i && e_rr) begin
      ms[m_free] = '{1, 0, int'(bus.rsv_id_i), cyc + 1 + int'(bus.delay_i), seq_ctr, 16'h0};
      seq_ctr++;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
    chk("m_rsv_ready", {31'b0, bus.rsv_ready_o}, {31'b0, e_rr});
    chk("m_rsp_in_ready", {31'b0, bus.rsp_in_ready_o}, {31'b0, e_ir});
    chk("m_rsp_out_valid", {31'b0, bus.rsp_out_valid_o}, {31'b0, e_ov});
    if (e_ov) chk("m_rsp_out", {16'b0, bus.rsp_out_o}, {16'b0, e_od});
    if (rst_n) chk("m_occupancy", {28'b0, bus.occupancy_o}, e_occ);
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit en, input bit rv, input int rid, input int dly, input bit iv,
                       input logic [15:0] idata, input bit ordy);
    bus.en_i            = en;
    bus.rsv_valid_i     = rv;
    bus.rsv_id_i        = 2'(rid);
    bus.delay_i         = 8'(dly);
    bus.rsp_in_valid_i  = iv;
    bus.rsp_in_i        = idata;
    bus.rsp_out_ready_i = ordy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0, 0);
    repeat (2) begin
      settle();
      chk("rst_out_valid", {31'b0, bus.rsp_out_valid_o}, 32'd0);
      advance();
    end
    chk("rst_occupancy", {28'b0, bus.occupancy_o}, 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  typedef struct {
    bit en, rv; int rid, dly; bit iv; logic [15:0] idata; bit ordy;
    bit rr, ir, ov; logic [15:0] od; int occ;
  } vec_t;

  function automatic vec_t mkv(input bit en, input bit rv, input int rid, input int dly,
                               input bit iv, input logic [15:0] idata, input bit ordy,
                               input bit rr, input bit ir, input bit ov, input logic [15:0] od,
                               input int occ);
    vec_t v;
    v.en = en; v.rv = rv; v.rid = rid; v.dly = dly; v.iv = iv; v.idata = idata; v.ordy = ordy;
    v.rr = rr; v.ir = ir; v.ov = ov; v.od = od; v.occ = occ;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    // Single id-1 transaction with D=5, then an unmatched id-3 response.
    vecs[0]  = mkv(1, 1, 1, 5, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 0);
    vecs[1]  = mkv(1, 0, 0, 0, 1, 16'hA5A1, 1,  1, 1, 0, 16'h0000, 1);
    vecs[2]  = mkv(1, 0, 0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 1);
    vecs[3]  = mkv(1, 0, 0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 1);
    vecs[4]  = mkv(1, 0, 0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 1);
    vecs[5]  = mkv(1, 0, 0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 1);
    vecs[6]  = mkv(1, 0, 0, 0, 0, 16'h0000, 1,  1, 0, 1, 16'hA5A1, 1);
    vecs[7]  = mkv(1, 0, 0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 0);
    vecs[8]  = mkv(1, 0, 0, 0, 1, 16'hBEE3, 1,  1, 0, 0, 16'h0000, 0);
    vecs[9]  = mkv(1, 1, 3, 0, 1, 16'hBEE3, 1,  1, 0, 0, 16'h0000, 0);
    vecs[10] = mkv(1, 0, 0, 0, 1, 16'hBEE3, 1,  1, 1, 0, 16'h0000, 1);
    vecs[11] = mkv(1, 0, 0, 0, 0, 16'h0000, 1,  1, 0, 1, 16'hBEE3, 1);
    vecs[12] = mkv(1, 0, 0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'h0000, 0);

    do_reset();
    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].en, vecs[k].rv, vecs[k].rid, vecs[k].dly, vecs[k].iv, vecs[k].idata,
            vecs[k].ordy);
      settle();
      chk($sformatf("v%0d_rsv_ready", k), {31'b0, bus.rsv_ready_o}, {31'b0, vecs[k].rr});
      chk($sformatf("v%0d_in_ready", k), {31'b0, bus.rsp_in_ready_o}, {31'b0, vecs[k].ir});
      chk($sformatf("v%0d_out_valid", k), {31'b0, bus.rsp_out_valid_o}, {31'b0, vecs[k].ov});
      if (vecs[k].ov) chk($sformatf("v%0d_out", k), {16'b0, bus.rsp_out_o}, {16'b0, vecs[k].od});
      chk($sformatf("v%0d_occ", k), {28'b0, bus.occupancy_o}, vecs[k].occ);
      advance();
    end

    // Late data: D=2 reserved in cycle 0, data in cycle 20, valid in cycle 21.
    do_reset();
    for (int c = 0; c < 23; c++) begin
      if (c == 0) drive(1, 1, 0, 2, 0, 16'h0, 1);
      else if (c == 20) drive(1, 0, 0, 0, 1, 16'h4440, 1);
      else drive(1, 0, 0, 0, 0, 16'h0, 1);
      settle();
      if (c == 20) chk("late_not_yet", {31'b0, bus.rsp_out_valid_o}, 32'd0);
      if (c == 21) begin
        chk("late_valid", {31'b0, bus.rsp_out_valid_o}, 32'd1);
        chk("late_data", {16'b0, bus.rsp_out_o}, 32'h4440);
      end
      advance();
    end

    // Per-ID ordering: A (D=10) must leave before B (D=0); B follows the next cycle.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      case (c)
        0:       drive(1, 1, 2, 10, 0, 16'h0, 1);
        1:       drive(1, 1, 2, 0, 0, 16'h0, 1);
        2:       drive(1, 0, 0, 0, 1, 16'h1112, 1);
        3:       drive(1, 0, 0, 0, 1, 16'h2222, 1);
        default: drive(1, 0, 0, 0, 0, 16'h0, 1);
      endcase
      settle();
      if (c == 10) chk("ord_a_early", {31'b0, bus.rsp_out_valid_o}, 32'd0);
      if (c == 11) begin
        chk("ord_a_valid", {31'b0, bus.rsp_out_valid_o}, 32'd1);
        chk("ord_a_data", {16'b0, bus.rsp_out_o}, 32'h1112);
      end
      if (c == 12) begin
        chk("ord_b_valid", {31'b0, bus.rsp_out_valid_o}, 32'd1);
        chk("ord_b_data", {16'b0, bus.rsp_out_o}, 32'h2222);
      end
      if (c == 13) chk("ord_drained", {31'b0, bus.rsp_out_valid_o}, 32'd0);
      advance();
    end

    // Full bank: a same-cycle release does not reopen reservation until the next cycle.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(1, 1, c % 4, 0, 0, 16'h0, 0);
      else if (c == 8) drive(1, 1, 0, 0, 1, 16'h0C30, 0);
      else if (c == 9) drive(1, 1, 1, 0, 0, 16'h0, 1);
      else if (c == 10) drive(1, 1, 1, 0, 0, 16'h0, 0);
      else drive(1, 0, 0, 0, 0, 16'h0, 0);
      settle();
      if (c < 8) chk("full_fill_ready", {31'b0, bus.rsv_ready_o}, 32'd1);
      if (c == 8) begin
        chk("full_ready_low", {31'b0, bus.rsv_ready_o}, 32'd0);
        chk("full_occ", {28'b0, bus.occupancy_o}, 32'd8);
      end
      if (c == 9) begin
        chk("full_rel_ready_low", {31'b0, bus.rsv_ready_o}, 32'd0);
        chk("full_rel_valid", {31'b0, bus.rsp_out_valid_o}, 32'd1);
      end
      if (c == 10) chk("full_ready_back", {31'b0, bus.rsv_ready_o}, 32'd1);
      if (c == 11) chk("full_refilled", {28'b0, bus.occupancy_o}, 32'd8);
      advance();
    end

    // Enable low blocks both inputs while the held slot still drains; backpressure holds output.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) drive(1, 1, 1, 0, 0, 16'h0, 0);
      else if (c == 1) drive(1, 1, 1, 0, 1, 16'h7771, 0);
      else if (c < 6) drive(0, 1, 1, 0, 1, 16'h8881, 0);
      else if (c == 6) drive(0, 1, 1, 0, 1, 16'h8881, 1);
      else drive(0, 0, 0, 0, 0, 16'h0, 0);
      settle();
      if (c >= 2 && c <= 6) begin
        chk("en_rsv_blocked", {31'b0, bus.rsv_ready_o}, 32'd0);
        chk("en_in_blocked", {31'b0, bus.rsp_in_ready_o}, 32'd0);
        chk("bp_valid", {31'b0, bus.rsp_out_valid_o}, 32'd1);
        chk("bp_data", {16'b0, bus.rsp_out_o}, 32'h7771);
      end
      if (c == 7) begin
        chk("en_drained", {31'b0, bus.rsp_out_valid_o}, 32'd0);
        chk("en_occ", {28'b0, bus.occupancy_o}, 32'd1);
      end
      advance();
    end

    // Randomized traffic against the model, with one mid-run reset.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n = (n != 1500);
      drive(($urandom % 10) != 0, ($urandom % 2) == 0, int'($urandom % 4),
            ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 12)),
            ($urandom % 10) < 6, 16'($urandom), ($urandom % 10) < 7);
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simmem_rsp_delay_slots.md
# simmem_rsp_delay_slots

Parametrised response-delay slot bank for the simulated memory controller. Each accepted request reserves a slot tagged with its ID and loads a runtime-programmable latency counter. The matching response from the real memory controller is stored in that slot. It is released downstream only once the latency has elapsed and all older same-ID responses have left. This generalises the fixed write-response bank to N IDs, N slots, arbitrary payload width and per-request runtime delay.

## Interface
- NumIds, 4, number of distinct transaction IDs
- IdW, 2, ID width; must satisfy 2^IdW >= NumIds
- NumSlots, 8, slot count (>= 2)
- DelayW, 8, width of delay counter and delay_i
- RspW, 16, response payload width; bits [IdW-1:0] carry the response ID

- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- en_i  in  1  enable; gates acceptance of reservations and responses
- delay_i  in  DelayW  latency loaded into a slot on reservation
- rsv_valid_i  in  1  reservation request valid
- rsv_ready_o  out  1  reservation accepted when valid & ready
- rsv_id_i  in  IdW  ID of reserving request
- rsp_in_valid_i  in  1  response from real memory controller valid
- rsp_in_ready_o  out  1  response accepted
- rsp_in_i  in  RspW  response payload
- rsp_out_valid_o  out  1  delayed response valid
- rsp_out_ready_i  in  1  downstream ready
- rsp_out_o  out  RspW  delayed response payload
- occupancy_o  out  $clog2(NumSlots+1)  count of non-free slots

## Operation
- Per-slot state: FREE, WAIT (reserved, no data), HELD (data stored). Per-slot registers: id, cnt (DelayW), rank ($clog2(NumSlots)), data (RspW).
- Reservation (rsv_valid_i & rsv_ready_o), target is the lowest-index FREE slot:
  - FREE->WAIT; id:=rsv_id_i; cnt:=delay_i.
  - rank := number of non-free slots with same id, minus 1 if a same-id slot is released this cycle.
- rsv_ready_o = rst_ni & en_i & (any slot FREE at cycle start). A slot freed this cycle is not reusable until the next cycle.
- Response input: the target is the WAIT slot with id == rsp_in_i[IdW-1:0] and the lowest rank. On acceptance it moves WAIT->HELD and data:=rsp_in_i.
- rsp_in_ready_o = rst_ni & en_i & (target exists). Responses without a matching WAIT slot stall; they are never dropped.
- Counter: every non-FREE slot with cnt != 0 decrements by 1 each cycle. It saturates at 0 and runs regardless of en_i.
- Eligible slot: HELD & cnt == 0 & rank == 0.
- rsp_out_valid_o = any eligible slot. If several are eligible, the lowest slot index wins. rsp_out_o = winner's data, registered with no bypass from rsp_in_i.
- Release (rsp_out_valid_o & rsp_out_ready_i): winner goes HELD->FREE, and every other non-free slot with the same id decrements rank.
- Per-ID output order equals reservation order. Cross-ID order is not guaranteed.
- occupancy_o = registered count of non-free slots: +1 on reservation, -1 on release, unchanged if both occur in the same cycle.
- en_i low: no new reservations or responses are accepted; existing slots keep counting and draining.

## Timing
- Reset (rst_ni low at a clock edge): all slots FREE, cnt/rank/data cleared, occupancy_o=0. While rst_ni is low, rsv_ready_o, rsp_in_ready_o and rsp_out_valid_o are 0. A reset mid-operation discards all slots.
- Reservation accepted in cycle t with delay D, response accepted in cycle a: the earliest rsp_out_valid_o is cycle max(t+1+D, a+1). D=0 with a<=t gives valid in t+1.
- Once asserted, rsp_out_valid_o and rsp_out_o stay stable until a handshake. Higher-priority slots cannot preempt the winner because the winner holds until released.
- Reservation, response input and release may all occur in the same cycle on distinct slots. All three update in parallel.
- Full (occupancy_o == NumSlots): rsv_ready_o=0. A same-cycle release does not raise it; readiness returns the cycle after.
- Counter wrap is impossible: cnt saturates at 0. delay_i = 2^DelayW-1 is legal.

## Test plan
- Single transaction, D=5: reserve id 1 in cycle 10, response in cycle 11 -> rsp_out_valid_o first high in cycle 16, payload matches, occupancy 1->0.
- Late data: reserve id 0 with D=2 at cycle 0, response at cycle 20 -> valid in cycle 21.
- Per-ID ordering: reserve id 2 with D=10, then id 2 with D=0; responses A then B -> A released before B, B valid the cycle after A's handshake.
- Full bank: 8 reservations with no releases -> rsv_ready_o=0. A release plus reservation attempt in the same cycle -> reservation accepted one cycle later.
- Enable and backpressure: en_i=0 -> both input readies 0 while a HELD slot still releases. rsp_out_ready_i=0 for 4 cycles -> output stable throughout.
- Unmatched response: response id 3 with no reservation -> rsp_in_ready_o=0. It is accepted in the cycle after an id 3 reservation.
